// File: rtl/button_cmd_encoder.sv
// Turns four raw front-panel buttons into one-shot ASCII command bytes for the
// pet statistics block: each button is synchronised, debounced and edge-detected.
module button_cmd_encoder #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int HOLD_CYCLES     = 4,
  parameter int GAP_CYCLES      = 4,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic       is_sleeping,
  output logic [7:0] cmd,
  output logic       issued,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_GAP     = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam int TMR_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);

  logic [3:0] stable_w;
  logic [3:0] press_w;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      logic             sync1_q, sync2_q;
      logic             stable_q, stable_d, stable_prev_q;
      logic             press_q;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // stable flips on the DEBOUNCE_CYCLES-th consecutive differing sample
      always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
          if (cnt_q == DB_LAST) begin
            stable_d = ~stable_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_q       <= 1'b0;
          sync2_q       <= 1'b0;
          stable_q      <= 1'b0;
          stable_prev_q <= 1'b0;
          press_q       <= 1'b0;
          cnt_q         <= '0;
        end else begin
          sync1_q       <= btn[gi];
          sync2_q       <= sync1_q;
          stable_q      <= stable_d;
          cnt_q         <= cnt_d;
          stable_prev_q <= stable_q;
          press_q       <= stable_q & ~stable_prev_q;
        end
      end

      assign stable_w[gi] = stable_q;
      assign press_w[gi]  = press_q;
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             issued_q, issued_d;
  logic             busy_q;
  logic [7:0]       code_w;

  // Lowest button index wins; button 3 toggles sleep/wake.
  always_comb begin
    if (press_w[0])      code_w = 8'h65;
    else if (press_w[1]) code_w = 8'h70;
    else if (press_w[2]) code_w = 8'h62;
    else if (is_sleeping) code_w = 8'h77;
    else                 code_w = 8'h73;
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    tmr_d    = tmr_q;
    issued_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_d = 8'h00;
        if (|press_w) begin
          cmd_d    = code_w;
          issued_d = 1'b1;
          tmr_d    = HOLD_LOAD;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tmr_q == '0) begin
          cmd_d   = 8'h00;
          tmr_d   = GAP_LOAD;
          state_d = ST_GAP;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_GAP: begin
        if (tmr_q == '0) begin
          state_d = ST_RELEASE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: begin
        // Wait for every button to be released so a held button cannot repeat.
        if (stable_w == 4'b0000) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cmd_q    <= 8'h00;
      tmr_q    <= '0;
      issued_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      tmr_q    <= tmr_d;
      issued_q <= issued_d;
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign cmd    = cmd_q;
  assign issued = issued_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_button_cmd_encoder.sv
// Bench for button_cmd_encoder: directed scenarios then random button traffic,
// every cycle compared against a timeline model of the command protocol.
module tb_button_cmd_encoder;

  localparam int D = 4;
  localparam int H = 4;
  localparam int G = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn = 4'b0000;
  logic       is_sleeping = 1'b0;
  logic [7:0] cmd;
  logic       issued;
  logic       busy;

  always #5 clk = ~clk;

  button_cmd_encoder #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .GAP_CYCLES(G),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn(btn),
    .is_sleeping(is_sleeping),
    .cmd(cmd),
    .issued(issued),
    .busy(busy)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Model state: edge counter, sampled-level pipeline, run lengths, and the
  // edge at which each button's press becomes visible to the command logic.
  int         cyc = 0;
  int         start_edge = 0;
  int         run_len[4];
  int         press_due[4];
  logic [3:0] samp1 = '0, samp2 = '0, deb = '0;
  bit         active = 1'b0;
  logic [7:0] code_m = 8'h00;
  logic [7:0] exp_cmd = 8'h00;
  logic       exp_issued = 1'b0;
  logic       exp_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      run_len[i]   = 0;
      press_due[i] = -1;
    end
    samp1 = '0; samp2 = '0; deb = '0;
    active = 1'b0; exp_cmd = 8'h00; exp_issued = 1'b0; exp_busy = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] b, input logic slp, input logic rst);
    bit picked;
    cyc++;
    if (rst) begin
      model_clear();
      return;
    end
    exp_issued = 1'b0;
    if (!active) begin
      exp_cmd = 8'h00;
      picked = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!picked && press_due[i] == cyc) begin
          picked = 1'b1;
          case (i)
            0: code_m = 8'h65;
            1: code_m = 8'h70;
            2: code_m = 8'h62;
            default: code_m = slp ? 8'h77 : 8'h73;
          endcase
        end
      end
      if (picked) begin
        active = 1'b1; start_edge = cyc; exp_cmd = code_m; exp_issued = 1'b1;
      end
    end else begin
      exp_cmd = (cyc - start_edge < H) ? code_m : 8'h00;
      if (cyc - start_edge >= H + G + 1 && deb == 4'b0000) active = 1'b0;
    end
    exp_busy = active;
    for (int i = 0; i < 4; i++) begin
      if (samp2[i] != deb[i]) begin
        run_len[i]++;
        if (run_len[i] == D) begin
          deb[i] = ~deb[i];
          run_len[i] = 0;
          if (deb[i]) press_due[i] = cyc + 2;
        end
      end else begin
        run_len[i] = 0;
      end
    end
    samp2 = samp1;
    samp1 = b;
  endtask

  task automatic tick(input logic [3:0] b, input logic slp, input logic rst);
    @(negedge clk);
    btn = b; is_sleeping = slp; reset = rst;
    @(posedge clk);
    model_edge(b, slp, rst);
    #1;
    chk("cmd", cmd, exp_cmd);
    chk("issued", issued, exp_issued);
    chk("busy", busy, exp_busy);
  endtask

  task automatic hold(input logic [3:0] b, input logic slp, input int n);
    for (int j = 0; j < n; j++) tick(b, slp, 1'b0);
  endtask

  // First raw sample at edge k must show the command at edge k+D+3.
  task automatic latency(input logic [3:0] b, input logic slp);
    int k, seen;
    k = cyc + 1;
    seen = -1;
    for (int j = 0; j < 15; j++) begin
      tick(b, slp, 1'b0);
      if (seen < 0 && cmd !== 8'h00) seen = cyc;
    end
    chk("latency", seen - k, D + 3);
  endtask

  initial begin
    logic [3:0] b;
    int         r;
    model_clear();
    tick(4'b0000, 1'b0, 1'b1);
    tick(4'b0000, 1'b0, 1'b1);
    hold(4'b0000, 1'b0, 3);

    latency(4'b0001, 1'b0);
    hold(4'b0001, 1'b0, 15);
    chk("busy_held", busy, 1'b1);
    hold(4'b0000, 1'b0, 20);

    hold(4'b0010, 1'b0, 3);
    hold(4'b0000, 1'b0, 12);

    hold(4'b0101, 1'b0, 25);
    hold(4'b0000, 1'b0, 20);
    hold(4'b0100, 1'b0, 25);
    hold(4'b0000, 1'b0, 20);

    hold(4'b1000, 1'b0, 25);
    hold(4'b0000, 1'b0, 20);
    hold(4'b1000, 1'b1, 25);
    hold(4'b0000, 1'b1, 20);

    hold(4'b0001, 1'b0, 9);
    hold(4'b0011, 1'b0, 25);
    hold(4'b0000, 1'b0, 20);

    hold(4'b0001, 1'b0, 8);
    chk("hold_before_reset", cmd, 8'h65);
    tick(4'b0001, 1'b0, 1'b1);
    latency(4'b0001, 1'b0);
    hold(4'b0001, 1'b0, 10);
    hold(4'b0000, 1'b0, 20);

    for (int seg = 0; seg < 200; seg++) begin
      r = $urandom_range(0, 9);
      if (r < 4) b = 4'b0000;
      else if (r < 8) b = 4'(1 << $urandom_range(0, 3));
      else b = 4'($urandom_range(0, 15));
      tick(b, 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
      hold(b, 1'($urandom_range(0, 1)), $urandom_range(0, 14));
    end
    hold(4'b0000, 1'b0, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
